button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Per-button input conditioning stage that feeds the menu state machine's btn_up/btn_down inputs.
- For each raw push-button it:
  - synchronises the input to clk_in;
  - debounces it;
  - emits a single-cycle press pulse;
  - optionally auto-repeats the pulse while the button is held, so a held up/down button scrolls the menu.
- Channels are fully independent; one instance serves all menu buttons.

Parameters:
- NUM_BTNS, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 650000, consecutive cycles the synchronised input must differ from the stable level before the stable level changes (10 ms at 65 MHz); must be >= 2.
- REPEAT_EN, 1, 1 enables hold-to-repeat pulses; 0 gives exactly one pulse per press.
- REPEAT_DELAY, 32500000, cycles from the initial press pulse to the first repeat pulse (0.5 s); must be >= 1.
- REPEAT_PERIOD, 6500000, cycles between subsequent repeat pulses (0.1 s); must be >= 1.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- btn_raw_in  input  NUM_BTNS  raw, asynchronous, bouncy button levels; 1 = pressed.
- btn_level_out  output  NUM_BTNS  debounced stable level per channel.
- btn_pulse_out  output  NUM_BTNS  one-cycle press/repeat pulse per channel; connects to menu btn_up/btn_down.

Behaviour:
- Reset: rst_n_in low asynchronously clears, for every channel:
  - sync flops, stable level, debounce counter and repeat counter;
  - FSM to IDLE;
  - btn_level_out = 0, btn_pulse_out = 0.
  - Effective mid-operation; no pulse is emitted during or on release of reset.
  - A button already held at reset release is seen as a new press: pulse after the full debounce.
- Synchroniser: two flops per channel (sync1, sync2); sync2 feeds the debouncer.
- Debounce (per channel):
  - Counter width is clog2(DEBOUNCE_CYCLES) + 1.
  - sync2 == stable: counter cleared to 0.
  - sync2 != stable: counter increments.
  - On the edge where the counter reaches DEBOUNCE_CYCLES-1, stable takes sync2 and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count; stable does not change.
- Latency: let E0 be the first edge sampling btn_raw_in = 1.
  - btn_level_out and the press pulse both appear after edge E0 + DEBOUNCE_CYCLES + 1.
  - The same latency applies to release on btn_level_out.
- All outputs are registered; btn_pulse_out is high for exactly one cycle per event.
- Pulse FSM per channel:
  - IDLE:
    - stable rises: pulse = 1, repeat counter = 0, go to DELAY (REPEAT_EN = 1) or HELD (REPEAT_EN = 0).
  - DELAY:
    - counter increments each cycle.
    - counter reaches REPEAT_DELAY-1: pulse = 1, counter = 0, go to REPEAT.
  - REPEAT:
    - counter increments each cycle.
    - counter reaches REPEAT_PERIOD-1: pulse = 1, counter = 0.
  - HELD: no pulses.
  - Any state except IDLE: stable falls -> IDLE, counter = 0, no pulse. Release takes priority over a same-cycle repeat pulse.
- Repeat counter width is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) + 1; it never wraps because it is cleared at each terminal count.
- Simultaneous events:
  - Channels never interact; two channels may pulse in the same cycle.
  - Downstream menu treats simultaneous up+down as no change; this block does not arbitrate.
- No pulse is ever generated on release, only on press and repeat.

Test Plan:
Bench parameters: NUM_BTNS = 2, DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3, REPEAT_EN = 1 unless stated.
- Clean press: ch0 raw 0 -> 1 before edge E0, held 5 cycles then released -> btn_level_out[0] = 1 and one btn_pulse_out[0] pulse after edge E0+5; level returns 0 five edges after release; no release pulse; ch1 stays 0.
- Bounce rejection: ch0 raw toggles 1,0,1,1,0 (each held 1 to 3 cycles, never 4 consecutive) -> btn_level_out[0] and btn_pulse_out[0] stay 0 throughout.
- Auto-repeat: ch0 held 40 cycles -> pulses at press P, P+10, P+13, P+16, ... until release; total count matches the schedule; release 2 cycles after a repeat pulse produces no further pulse.
- REPEAT_EN = 0: ch0 held 40 cycles -> exactly one pulse.
- Simultaneous: both channels pressed on the same edge -> btn_pulse_out = 2'b11 for exactly one cycle.
- Reset mid-hold: assert rst_n_in low asynchronously (between edges) while ch0 is in REPEAT -> outputs 0 immediately; release reset with ch0 still held -> new pulse after DEBOUNCE_CYCLES+2 edges, then the repeat schedule restarts at +10.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchroniser, debouncer and press/auto-repeat pulse generator
//
// Ports:
//   clk_in         system clock
//   rst_n_in       asynchronous active-low reset
//   btn_raw_in     raw bouncy button levels, 1 = pressed (asynchronous to clk_in)
//   btn_level_out  debounced stable level per channel (registered)
//   btn_pulse_out  one-cycle press / auto-repeat pulse per channel (registered)
module button_conditioner #(
    parameter int NUM_BTNS        = 2,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_PERIOD   = 6500000
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [NUM_BTNS-1:0] btn_raw_in,
    output logic [NUM_BTNS-1:0] btn_level_out,
    output logic [NUM_BTNS-1:0] btn_pulse_out
);

    localparam int DCW  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX) + 1;

    localparam logic [DCW-1:0] DB_LAST     = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HELD   = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        logic           sync1;
        logic           sync2;
        logic           stable;
        logic [DCW-1:0] db_cnt;
        logic           differ;
        logic           commit;
        logic           rise;
        logic           fall;

        state_t         state;
        state_t         state_nxt;
        logic [RCW-1:0] rpt_cnt;
        logic [RCW-1:0] rpt_nxt;
        logic           pulse;
        logic           pulse_nxt;

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= btn_raw_in[i];
                sync2 <= sync1;
            end
        end

        // The stable level flips on the edge that evaluates the counter at its
        // last value; rise/fall mark that edge so the press pulse lands in the
        // same cycle that btn_level_out rises.
        assign differ = (sync2 != stable);
        assign commit = differ && (db_cnt == DB_LAST);
        assign rise   = commit && sync2;
        assign fall   = commit && !sync2;

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                stable <= 1'b0;
                db_cnt <= '0;
            end else if (!differ) begin
                db_cnt <= '0;
            end else if (commit) begin
                stable <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                state   <= IDLE;
                rpt_cnt <= '0;
                pulse   <= 1'b0;
            end else begin
                state   <= state_nxt;
                rpt_cnt <= rpt_nxt;
                pulse   <= pulse_nxt;
            end
        end

        // Release is checked first in every held state so it always beats a
        // repeat pulse falling due on the same edge.
        always_comb begin
            state_nxt = state;
            rpt_nxt   = rpt_cnt;
            pulse_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        pulse_nxt = 1'b1;
                        rpt_nxt   = '0;
                        state_nxt = (REPEAT_EN != 0) ? DELAY : HELD;
                    end
                end
                DELAY: begin
                    if (fall) begin
                        state_nxt = IDLE;
                        rpt_nxt   = '0;
                    end else if (rpt_cnt == DELAY_LAST) begin
                        pulse_nxt = 1'b1;
                        rpt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        rpt_nxt = rpt_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state_nxt = IDLE;
                        rpt_nxt   = '0;
                    end else if (rpt_cnt == PERIOD_LAST) begin
                        pulse_nxt = 1'b1;
                        rpt_nxt   = '0;
                    end else begin
                        rpt_nxt = rpt_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state_nxt = IDLE;
                        rpt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rpt_nxt   = '0;
                end
            endcase
        end

        assign btn_level_out[i] = stable;
        assign btn_pulse_out[i] = pulse;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic [1:0] raw_a;
    logic [1:0] level_a;
    logic [1:0] pulse_a;
    logic [1:0] raw_b;
    logic [1:0] level_b;
    logic [1:0] pulse_b;

    int errors = 0;
    int checks = 0;
    int npulse;

    button_conditioner #(
        .NUM_BTNS(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .btn_raw_in(raw_a),
        .btn_level_out(level_a), .btn_pulse_out(pulse_a)
    );

    button_conditioner #(
        .NUM_BTNS(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .btn_raw_in(raw_b),
        .btn_level_out(level_b), .btn_pulse_out(pulse_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        logic bv [5];
        int   bd [5];
        bv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bd = '{3, 1, 1, 2, 2};

        rst_n = 1'b0;
        raw_a = 2'b00;
        raw_b = 2'b00;
        repeat (3) cyc();
        chk("reset_level_a", int'(level_a), 0);
        chk("reset_pulse_a", int'(pulse_a), 0);
        chk("reset_level_b", int'(level_b), 0);
        chk("reset_pulse_b", int'(pulse_b), 0);
        rst_n = 1'b1;
        repeat (3) cyc();

        // clean press: raw sampled high on edges k=0..4
        raw_a = 2'b01;
        for (int k = 0; k < 14; k++) begin
            cyc();
            if (k == 4) raw_a = 2'b00;
            chk("press_level0", int'(level_a[0]), int'(k >= 5 && k <= 9));
            chk("press_pulse0", int'(pulse_a[0]), int'(k == 5));
            chk("press_ch1", int'({level_a[1], pulse_a[1]}), 0);
        end

        // bounce: never four consecutive high samples
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < bd[i]; j++) begin
                raw_a[0] = bv[i];
                cyc();
                chk("bounce_level", int'(level_a[0]), 0);
                chk("bounce_pulse", int'(pulse_a[0]), 0);
            end
        end
        raw_a = 2'b00;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("bounce_tail_level", int'(level_a[0]), 0);
            chk("bounce_tail_pulse", int'(pulse_a[0]), 0);
        end

        // auto-repeat: held 40 samples, press at 5, repeats 15,18,...,42; 45 lost to release
        npulse = 0;
        raw_a = 2'b01;
        for (int k = 0; k < 56; k++) begin
            cyc();
            if (k == 39) raw_a = 2'b00;
            if (pulse_a[0]) npulse++;
            chk("repeat_pulse", int'(pulse_a[0]),
                int'(k == 5 || (k >= 15 && k < 45 && ((k - 15) % 3) == 0)));
            chk("repeat_level", int'(level_a[0]), int'(k >= 5 && k <= 44));
        end
        chk("repeat_count", npulse, 11);

        // REPEAT_EN = 0: exactly one pulse
        npulse = 0;
        raw_b = 2'b01;
        for (int k = 0; k < 56; k++) begin
            cyc();
            if (k == 39) raw_b = 2'b00;
            if (pulse_b[0]) npulse++;
            chk("norep_pulse", int'(pulse_b[0]), int'(k == 5));
        end
        chk("norep_count", npulse, 1);

        // simultaneous press on both channels
        raw_a = 2'b11;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (k == 6) raw_a = 2'b00;
            chk("simul_pulse", int'(pulse_a), (k == 5) ? 3 : 0);
            chk("simul_level", int'(level_a), (k >= 5 && k <= 11) ? 3 : 0);
        end

        // reset while in REPEAT
        raw_a = 2'b01;
        for (int k = 0; k <= 20; k++) begin
            cyc();
            chk("prereset_pulse", int'(pulse_a[0]), int'(k == 5 || k == 15 || k == 18));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_level", int'(level_a), 0);
        chk("async_reset_pulse", int'(pulse_a), 0);
        cyc();
        chk("in_reset_level", int'(level_a), 0);
        chk("in_reset_pulse", int'(pulse_a), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 18; k++) begin
            cyc();
            chk("postreset_pulse", int'(pulse_a[0]), int'(k == 5 || k == 15));
            chk("postreset_level", int'(level_a[0]), int'(k >= 5));
        end
        raw_a = 2'b00;
        repeat (8) cyc();
        chk("final_level", int'(level_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
